red_pitaya_hk_dna_seq: RTL and testbench

//  Sequencer for the DNA_PORT primitive in housekeeping. Generates the DNA_PORT

---
 rtl/red_pitaya_hk_dna_seq_if.sv | 34 +++
 rtl/red_pitaya_hk_dna_seq.sv | 178 +++++++++++++++++
 tb/tb_red_pitaya_hk_dna_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_hk_dna_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_hk_dna_seq_if
//  Purpose  : Signal bundle between the DNA sequencer and the DNA_PORT
//             primitive.
//  Signals  : dna_clk   - DNA_PORT.CLK (before BUFG)
//             dna_read  - DNA_PORT.READ
//             dna_shift - DNA_PORT.SHIFT
//             dna_dout  - DNA_PORT.DOUT
//  Modports : master - sequencer side (drives clk/read/shift, samples dout)
//             slave  - DNA_PORT side
//  Revision : 1.0 - initial release
// ============================================================================
interface red_pitaya_hk_dna_seq_if;
    logic dna_clk;
    logic dna_read;
    logic dna_shift;
    logic dna_dout;

    modport master (
        output dna_clk,
        output dna_read,
        output dna_shift,
        input  dna_dout
    );

    modport slave (
        input  dna_clk,
        input  dna_read,
        input  dna_shift,
        output dna_dout
    );
endinterface
`default_nettype wire

// File: rtl/red_pitaya_hk_dna_seq.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_hk_dna_seq
//  Purpose  : Sequencer for the DNA_PORT primitive. Generates the DNA clock,
//             READ and SHIFT controls and deserialises the device DNA (MSB
//             first). One readout runs after reset (AUTO_START) and one per
//             accepted start_i pulse.
//  Ports    : clk_i       - system clock
//             rstn_i      - asynchronous active-low reset
//             start_i     - 1-cycle re-read request, accepted only when idle
//             busy_o      - readout in progress
//             dna_valid_o - dna_value_o holds a complete readout
//             dna_value_o - last completed DNA value
//             dna_port    - DNA_PORT clock/read/shift/dout bundle (master)
//  Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_hk_dna_seq #(
    parameter int CLK_DIV    = 4,     // clk_i cycles per DNA clock half-period (2..255)
    parameter int DNA_BITS   = 57,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    dna_valid_o,
    output logic [DNA_BITS-1:0]     dna_value_o,
    red_pitaya_hk_dna_seq_if.master dna_port
);

    localparam int         BCW      = $clog2(DNA_BITS + 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DNA_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [7:0]          r_div_cnt;
    logic [BCW-1:0]      r_bit_cnt;
    logic [DNA_BITS-1:0] r_shreg;
    logic                r_auto;
    logic                r_busy;
    logic                r_valid;
    logic [DNA_BITS-1:0] r_value;
    logic                r_dna_clk;
    logic                r_read;
    logic                r_shift;

    logic [1:0]          w_state_nxt;
    logic [7:0]          w_div_cnt_nxt;
    logic [BCW-1:0]      w_bit_cnt_nxt;
    logic [DNA_BITS-1:0] w_shreg_nxt;
    logic                w_busy_nxt;
    logic                w_valid_nxt;
    logic [DNA_BITS-1:0] w_value_nxt;
    logic                w_dna_clk_nxt;
    logic                w_read_nxt;
    logic                w_shift_nxt;

    logic w_start;
    logic w_div_last;
    logic w_sample;
    logic w_last_bit;

    // r_auto is high only in the first cycle after reset release.
    assign w_start    = start_i | r_auto;
    assign w_div_last = (r_div_cnt == DIV_LAST);
    // DOUT is sampled at the end of each low phase, just before the rising
    // edge that would advance DNA_PORT to the next bit.
    assign w_sample   = (r_state == ST_SHIFT) && w_div_last && !r_dna_clk;
    assign w_last_bit = (r_bit_cnt == BIT_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)                 w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_div_last && r_dna_clk) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_sample && w_last_bit)  w_state_nxt = ST_DONE;
            ST_DONE:                               w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------ next registered values
    always_comb begin
        w_div_cnt_nxt = 8'd0;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_valid_nxt   = r_valid;
        w_value_nxt   = r_value;
        w_dna_clk_nxt = 1'b0;

        // READ/SHIFT/busy follow the state being entered so they change on
        // the same edge as the state itself.
        w_read_nxt    = (w_state_nxt == ST_LOAD);
        w_shift_nxt   = (w_state_nxt == ST_SHIFT);
        w_busy_nxt    = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT);

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_valid_nxt   = 1'b0;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_LOAD: begin
                w_div_cnt_nxt = w_div_last ? 8'd0 : r_div_cnt + 8'd1;
                w_dna_clk_nxt = w_div_last ? ~r_dna_clk : r_dna_clk;
            end
            ST_SHIFT: begin
                w_div_cnt_nxt = w_div_last ? 8'd0 : r_div_cnt + 8'd1;
                w_dna_clk_nxt = w_div_last ? ~r_dna_clk : r_dna_clk;
                if (w_sample) begin
                    w_shreg_nxt   = {r_shreg[DNA_BITS-2:0], dna_port.dna_dout};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    // No rising edge after the final sample.
                    if (w_last_bit) begin
                        w_dna_clk_nxt = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                w_value_nxt = r_shreg;
                w_valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------- datapath and outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_div_cnt <= 8'd0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_auto    <= AUTO_START;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_value   <= '0;
            r_dna_clk <= 1'b0;
            r_read    <= 1'b0;
            r_shift   <= 1'b0;
        end else begin
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_auto    <= 1'b0;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
            r_value   <= w_value_nxt;
            r_dna_clk <= w_dna_clk_nxt;
            r_read    <= w_read_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    assign busy_o             = r_busy;
    assign dna_valid_o        = r_valid;
    assign dna_value_o        = r_value;
    assign dna_port.dna_clk   = r_dna_clk;
    assign dna_port.dna_read  = r_read;
    assign dna_port.dna_shift = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_hk_dna_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_red_pitaya_hk_dna_seq
//  Purpose  : Self-checking bench for red_pitaya_hk_dna_seq. Two instances:
//             A (CLK_DIV=4, AUTO_START=1) and B (CLK_DIV=2, AUTO_START=0),
//             each attached to a behavioural DNA_PORT model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_hk_dna_seq;

    localparam int NB    = 57;
    localparam int DIV_A = 4;
    localparam int DIV_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn_a, rstn_b, start_a, start_b;
    logic          busy_a, valid_a, busy_b, valid_b;
    logic [NB-1:0] value_a, value_b;

    red_pitaya_hk_dna_seq_if if_a ();
    red_pitaya_hk_dna_seq_if if_b ();

    red_pitaya_hk_dna_seq #(.CLK_DIV(DIV_A), .DNA_BITS(NB), .AUTO_START(1'b1)) dut_a (
        .clk_i       (clk),
        .rstn_i      (rstn_a),
        .start_i     (start_a),
        .busy_o      (busy_a),
        .dna_valid_o (valid_a),
        .dna_value_o (value_a),
        .dna_port    (if_a)
    );

    red_pitaya_hk_dna_seq #(.CLK_DIV(DIV_B), .DNA_BITS(NB), .AUTO_START(1'b0)) dut_b (
        .clk_i       (clk),
        .rstn_i      (rstn_b),
        .start_i     (start_b),
        .busy_o      (busy_b),
        .dna_valid_o (valid_b),
        .dna_value_o (value_b),
        .dna_port    (if_b)
    );

    // ------------------------------------------------ DNA_PORT models
    logic [NB-1:0] dna_a_val, dna_b_val;
    logic [NB-1:0] sr_a = '0;
    logic [NB-1:0] sr_b = '0;
    assign if_a.dna_dout = sr_a[NB-1];
    assign if_b.dna_dout = sr_b[NB-1];

    always @(posedge if_a.dna_clk) begin
        if (if_a.dna_read)       sr_a <= dna_a_val;
        else if (if_a.dna_shift) sr_a <= {sr_a[NB-2:0], 1'b0};
    end
    always @(posedge if_b.dna_clk) begin
        if (if_b.dna_read)       sr_b <= dna_b_val;
        else if (if_b.dna_shift) sr_b <= {sr_b[NB-2:0], 1'b0};
    end

    // ------------------------------------------------ protocol monitors
    int   edges_a, read_edges_a, read_late_a, overlap_a, vrise_a, edges_b;
    logic valid_a_q = 1'b0;

    always @(posedge if_a.dna_clk) begin
        if (if_a.dna_read) begin
            read_edges_a++;
            if (edges_a != 0) read_late_a++;
        end
        edges_a++;
    end
    always @(posedge if_b.dna_clk) edges_b++;

    always @(negedge clk) begin
        if (if_a.dna_read && if_a.dna_shift) overlap_a++;
        if (valid_a && !valid_a_q) vrise_a++;
        valid_a_q = valid_a;
    end

    // ------------------------------------------------ checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Readout length from the start-accept edge to dna_valid_o=1.
    function automatic int lat(input int div);
        return (2 * NB + 1) * div + 1;
    endfunction

    function automatic logic [NB-1:0] rand57();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NB-1:0];
    endfunction

    task automatic clear_mon_a();
        edges_a      = 0;
        read_edges_a = 0;
        read_late_a  = 0;
        overlap_a    = 0;
    endtask

    // Entered at the negedge right after the accept edge of instance A.
    task automatic wait_check_a(input logic [NB-1:0] v, input int inj,
                                input logic [NB-1:0] old, input string tag);
        int cyc;
        bit held;
        int rises0;
        cyc    = 0;
        held   = 1'b1;
        rises0 = vrise_a;
        while (!valid_a && cyc < 3000) begin
            if (value_a !== old) held = 1'b0;
            if (cyc == inj) start_a = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_a = 1'b0;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat(DIV_A)));
        check({tag, "_value"}, 64'(value_a), 64'(v));
        check({tag, "_old_held"}, 64'(held), 64'd1);
        check({tag, "_edges"}, 64'(edges_a), 64'(NB));
        check({tag, "_read_edges"}, 64'(read_edges_a), 64'd1);
        check({tag, "_read_first"}, 64'(read_late_a), 64'd0);
        check({tag, "_overlap"}, 64'(overlap_a), 64'd0);
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, 64'(vrise_a - rises0), 64'd1);
        check({tag, "_busy_end"}, 64'(busy_a), 64'd0);
    endtask

    task automatic readout_a(input logic [NB-1:0] v, input int inj, input string tag);
        logic [NB-1:0] old;
        old       = value_a;
        dna_a_val = v;
        clear_mon_a();
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        check({tag, "_valid_fall"}, 64'(valid_a), 64'd0);
        check({tag, "_busy_rise"}, 64'(busy_a), 64'd1);
        wait_check_a(v, inj, old, tag);
    endtask

    initial begin
        int            k;
        int            cyc;
        int            rises;
        logic [NB-1:0] v;

        rstn_a    = 1'b0;
        rstn_b    = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        edges_b   = 0;
        vrise_a   = 0;
        clear_mon_a();
        dna_a_val = 57'h0823456789ABCDE;
        dna_b_val = rand57();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_value", 64'(value_a), 64'd0);
        check("rst_clk", 64'(if_a.dna_clk), 64'd0);
        check("rst_read", 64'(if_a.dna_read), 64'd0);
        check("rst_shift", 64'(if_a.dna_shift), 64'd0);

        // Automatic readout after reset release
        #2;
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("auto_busy", 64'(busy_a), 64'd1);
        wait_check_a(57'h0823456789ABCDE, -1, '0, "auto");

        // Software re-read with all-ones value
        repeat (5) @(negedge clk);
        readout_a(57'h1FFFFFFFFFFFFFF, -1, "reread");

        // start_i during a readout is dropped
        readout_a(rand57(), 100, "busy_start");
        rises = vrise_a;
        repeat (600) @(negedge clk);
        check("busy_start_no_second", 64'(vrise_a - rises), 64'd0);
        check("busy_start_valid_kept", 64'(valid_a), 64'd1);

        // Random values, idle gaps and dropped starts
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            readout_a(rand57(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 450)) : -1, "rand");
        end

        // Asynchronous reset in the middle of SHIFT
        dna_a_val = rand57();
        clear_mon_a();
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (edges_a < 31 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_bit30", 64'(edges_a >= 31), 64'd1);
        #2;
        rstn_a = 1'b0;
        #1;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_valid", 64'(valid_a), 64'd0);
        check("abort_value", 64'(value_a), 64'd0);
        check("abort_clk", 64'(if_a.dna_clk), 64'd0);
        check("abort_read", 64'(if_a.dna_read), 64'd0);
        check("abort_shift", 64'(if_a.dna_shift), 64'd0);
        repeat (3) @(negedge clk);
        v         = rand57();
        dna_a_val = v;
        clear_mon_a();
        #2;
        rstn_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_restart_busy", 64'(busy_a), 64'd1);
        wait_check_a(v, -1, '0, "abort_restart");

        // Instance B: no automatic start, CLK_DIV=2
        check("b_idle_busy", 64'(busy_b), 64'd0);
        check("b_idle_valid", 64'(valid_b), 64'd0);
        check("b_idle_edges", 64'(edges_b), 64'd0);
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        check("b_busy_rise", 64'(busy_b), 64'd1);
        cyc = 0;
        while (!valid_b && cyc < 3000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("b_latency", 64'(cyc), 64'(lat(DIV_B)));
        check("b_value", 64'(value_b), 64'(dna_b_val));
        check("b_edges", 64'(edges_b), 64'(NB));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
